// File: rtl/bcd_convert_param.sv
// bcd_convert_param: parametrised sequential binary-to-BCD converter
// (double-dabble, one input bit per clock).
//
// Parameters:
//   BIN_W  - binary input width (4..32)
//   DIGITS - number of BCD output digits (1..10)
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   ena        - start request, sampled only when not busy
//   bin_d_in   - unsigned binary input, captured on the accepting edge
//   bcd_d_out  - registered BCD result, digit 0 in bits [3:0]
//   rdy        - one-cycle pulse, result valid
//   busy       - conversion in progress
//   ovf        - result exceeded 10^DIGITS-1, held with bcd_d_out
//   blank_out  - leading-zero blanking mask (only with BCD_LZB_EN defined)
//
// Optional feature macro: BCD_LZB_EN (adds blank_out).
module bcd_convert_param #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [BIN_W-1:0]      bin_d_in,
    output logic [4*DIGITS-1:0]   bcd_d_out,
    output logic                  rdy,
    output logic                  busy,
    output logic                  ovf
`ifdef BCD_LZB_EN
    ,
    output logic [DIGITS-1:0]     blank_out
`endif
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state, state_nx;
    logic [SR_W-1:0]   sr, sr_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              acc, acc_nx;
    logic [BCD_W-1:0]  bcd_nx;
    logic              ovf_nx, rdy_nx, busy_nx;
    logic [SR_W-1:0]   adj;
    logic [SR_W-1:0]   shifted;
    logic              top_bit;

`ifdef BCD_LZB_EN
    // Every digit above 0 blanked: a zero result still shows one "0".
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);
    logic [DIGITS-1:0] blank_nx;
    logic [DIGITS-1:0] blank_calc;
    logic              all_zero;
`endif

    // Add-3 correction per digit, then one-bit left shift of {bcd, bin}
    always_comb begin
        adj = sr;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (adj[BIN_W + 4*i +: 4] >= 4'd5) begin
                adj[BIN_W + 4*i +: 4] = adj[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        top_bit = adj[SR_W-1];
        shifted = {adj[SR_W-2:0], 1'b0};
    end

`ifdef BCD_LZB_EN
    // Digit i blanked when it and every higher digit are zero (i >= 1)
    always_comb begin
        blank_calc = '0;
        all_zero   = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            all_zero      = all_zero && (shifted[BIN_W + 4*i +: 4] == 4'd0);
            blank_calc[i] = all_zero;
        end
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = cnt;
        acc_nx   = acc;
        bcd_nx   = bcd_d_out;
        ovf_nx   = ovf;
        rdy_nx   = 1'b0;
        busy_nx  = 1'b0;
`ifdef BCD_LZB_EN
        blank_nx = blank_out;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if (ena) begin
                    sr_nx    = {{BCD_W{1'b0}}, bin_d_in};
                    cnt_nx   = '0;
                    acc_nx   = 1'b0;
                    busy_nx  = 1'b1;
                    state_nx = S_CONV;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_CONV: begin
                sr_nx   = shifted;
                acc_nx  = acc | top_bit;
                cnt_nx  = cnt + CNT_W'(1);
                busy_nx = 1'b1;
                if (cnt == CNT_W'(BIN_W - 1)) begin
                    state_nx = S_DONE;
                    rdy_nx   = 1'b1;
                    busy_nx  = 1'b0;
                    bcd_nx   = shifted[SR_W-1:BIN_W];
                    ovf_nx   = acc | top_bit;
`ifdef BCD_LZB_EN
                    blank_nx = blank_calc;
`endif
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            sr        <= '0;
            cnt       <= '0;
            acc       <= 1'b0;
            bcd_d_out <= '0;
            ovf       <= 1'b0;
            rdy       <= 1'b0;
            busy      <= 1'b0;
`ifdef BCD_LZB_EN
            blank_out <= BLANK_RST;
`endif
        end else begin
            state     <= state_nx;
            sr        <= sr_nx;
            cnt       <= cnt_nx;
            acc       <= acc_nx;
            bcd_d_out <= bcd_nx;
            ovf       <= ovf_nx;
            rdy       <= rdy_nx;
            busy      <= busy_nx;
`ifdef BCD_LZB_EN
            blank_out <= blank_nx;
`endif
        end
    end

endmodule

// File: tb/tb_bcd_convert_param.sv
// Testbench for bcd_convert_param: three instances (8b/3d, 16b/5d, 8b/2d),
// vector table, back-to-back, ignore/abort sequences and random values
// checked against a decimal-arithmetic reference model.
module tb_bcd_convert_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ena0 = 1'b0, ena1 = 1'b0, ena2 = 1'b0;
    logic [7:0]  bin0 = '0;
    logic [15:0] bin1 = '0;
    logic [7:0]  bin2 = '0;
    logic [11:0] bcd0;
    logic [19:0] bcd1;
    logic [7:0]  bcd2;
    logic        rdy0, rdy1, rdy2, busy0, busy1, busy2, ovf0, ovf1, ovf2;
`ifdef BCD_LZB_EN
    logic [2:0]  blank0;
    logic [4:0]  blank1;
    logic [1:0]  blank2;
`endif

    bcd_convert_param #(.BIN_W(8), .DIGITS(3)) u8 (
        .clk(clk), .rst(rst), .ena(ena0), .bin_d_in(bin0), .bcd_d_out(bcd0),
        .rdy(rdy0), .busy(busy0), .ovf(ovf0)
`ifdef BCD_LZB_EN
        , .blank_out(blank0)
`endif
    );
    bcd_convert_param #(.BIN_W(16), .DIGITS(5)) u16 (
        .clk(clk), .rst(rst), .ena(ena1), .bin_d_in(bin1), .bcd_d_out(bcd1),
        .rdy(rdy1), .busy(busy1), .ovf(ovf1)
`ifdef BCD_LZB_EN
        , .blank_out(blank1)
`endif
    );
    bcd_convert_param #(.BIN_W(8), .DIGITS(2)) u82 (
        .clk(clk), .rst(rst), .ena(ena2), .bin_d_in(bin2), .bcd_d_out(bcd2),
        .rdy(rdy2), .busy(busy2), .ovf(ovf2)
`ifdef BCD_LZB_EN
        , .blank_out(blank2)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference model: plain decimal arithmetic
    function automatic logic [63:0] model_bcd(input longint v, input int digits);
        logic [63:0] r = '0;
        longint      x = v;
        for (int d = 0; d < digits; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic model_ovf(input longint v, input int digits);
        longint lim = 1;
        for (int d = 0; d < digits; d++) lim = lim * 10;
        return v >= lim;
    endfunction

    function automatic logic [7:0] model_blank(input longint v, input int digits);
        logic [7:0] b = '0;
        longint     p = 1;
        for (int i = 1; i < digits; i++) begin
            p = p * 10;
            b[i] = (v % (p * 100000) < p) || (v < p);
            b[i] = ((v % model_pow(digits)) < p);
        end
        return b;
    endfunction

    function automatic longint model_pow(input int digits);
        longint lim = 1;
        for (int d = 0; d < digits; d++) lim = lim * 10;
        return lim;
    endfunction

    function automatic int bin_w(input int sel);
        return (sel == 1) ? 16 : 8;
    endfunction

    function automatic int digits_of(input int sel);
        return (sel == 0) ? 3 : (sel == 1) ? 5 : 2;
    endfunction

    function automatic logic get_rdy(input int sel);
        return (sel == 0) ? rdy0 : (sel == 1) ? rdy1 : rdy2;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
    endfunction

    task automatic drive(input int sel, input logic e, input logic [31:0] v);
        case (sel)
            0:       begin ena0 = e; bin0 = v[7:0];  end
            1:       begin ena1 = e; bin1 = v[15:0]; end
            default: begin ena2 = e; bin2 = v[7:0];  end
        endcase
    endtask

    task automatic read_out(input int sel, output logic [63:0] bcd, output logic o, output logic [7:0] blank);
        blank = '0;
        case (sel)
            0: begin bcd = 64'(bcd0); o = ovf0;
`ifdef BCD_LZB_EN
                blank = 8'(blank0);
`endif
            end
            1: begin bcd = 64'(bcd1); o = ovf1;
`ifdef BCD_LZB_EN
                blank = 8'(blank1);
`endif
            end
            default: begin bcd = 64'(bcd2); o = ovf2;
`ifdef BCD_LZB_EN
                blank = 8'(blank2);
`endif
            end
        endcase
    endtask

    // One conversion from idle; lat counts samples after the accepting edge
    task automatic conv(input int sel, input logic [31:0] val, output logic [63:0] bcd,
                        output logic o, output logic [7:0] blank, output int lat, output int bcnt);
        @(negedge clk);
        drive(sel, 1'b1, val);
        @(negedge clk);
        drive(sel, 1'b0, val);
        lat  = 1;
        bcnt = 0;
        while (!get_rdy(sel) && lat < 60) begin
            if (get_busy(sel)) bcnt++;
            @(negedge clk);
            lat++;
        end
        read_out(sel, bcd, o, blank);
    endtask

    typedef struct {
        int          sel;
        logic [31:0] val;
        logic [63:0] exp_bcd;
        logic        exp_ovf;
        logic [7:0]  exp_blank;
    } vec_t;

    task automatic run_and_check(input string tag, input int sel, input logic [31:0] val,
                                 input logic [63:0] eb, input logic eo, input logic [7:0] ebl);
        logic [63:0] bcd;
        logic        o;
        logic [7:0]  blank;
        int          lat, bcnt;
        conv(sel, val, bcd, o, blank, lat, bcnt);
        check({tag, " latency"}, 64'(lat), 64'(bin_w(sel) + 1));
        check({tag, " busy_cycles"}, 64'(bcnt), 64'(bin_w(sel)));
        check({tag, " bcd"}, bcd, eb);
        check({tag, " ovf"}, 64'(o), 64'(eo));
`ifdef BCD_LZB_EN
        check({tag, " blank"}, 64'(blank), 64'(ebl));
`endif
        @(negedge clk);
        check({tag, " rdy_one_cycle"}, 64'(get_rdy(sel)), 64'd0);
    endtask

    initial begin
        vec_t vecs[9];
        int   vals[6];
        int   idx, cyc, last, k;
        logic seen;

        vecs[0] = '{0, 255,   64'h255,   1'b0, 8'b000};
        vecs[1] = '{0, 0,     64'h000,   1'b0, 8'b110};
        vecs[2] = '{0, 7,     64'h007,   1'b0, 8'b110};
        vecs[3] = '{0, 50,    64'h050,   1'b0, 8'b100};
        vecs[4] = '{0, 205,   64'h205,   1'b0, 8'b000};
        vecs[5] = '{1, 65535, 64'h65535, 1'b0, 8'b00000};
        vecs[6] = '{1, 1000,  64'h01000, 1'b0, 8'b10000};
        vecs[7] = '{2, 123,   64'h23,    1'b1, 8'b00};
        vecs[8] = '{2, 42,    64'h42,    1'b0, 8'b00};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset bcd0", 64'(bcd0), 64'd0);
        check("reset rdy/busy/ovf", {61'd0, rdy0, busy0, ovf0}, 64'd0);
        check("reset bcd1", 64'(bcd1), 64'd0);
`ifdef BCD_LZB_EN
        check("reset blank0", 64'(blank0), 64'b110);
        check("reset blank1", 64'(blank1), 64'b11110);
`endif

        for (int i = 0; i < 9; i++)
            run_and_check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].val,
                          vecs[i].exp_bcd, vecs[i].exp_ovf, vecs[i].exp_blank);

        // Back-to-back with ena held high
        vals = '{0, 9, 10, 99, 100, 128};
        @(negedge clk);
        ena0 = 1'b1;
        bin0 = 8'(vals[0]);
        idx = 0; cyc = 0; last = 0;
        while (idx < 6 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (rdy0) begin
                check($sformatf("b2b bcd %0d", idx), 64'(bcd0), model_bcd(vals[idx], 3));
                if (idx > 0) check($sformatf("b2b spacing %0d", idx), 64'(cyc - last), 64'd9);
                last = cyc;
                idx++;
                if (idx < 6) bin0 = 8'(vals[idx]);
                else ena0 = 1'b0;
            end
        end
        ena0 = 1'b0;
        check("b2b count", 64'(idx), 64'd6);
        repeat (2) @(negedge clk);

        // ena while busy is ignored
        @(negedge clk);
        ena0 = 1'b1; bin0 = 8'd200;
        @(negedge clk);
        ena0 = 1'b0;
        k = 1;
        while (!rdy0 && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 3) begin ena0 = 1'b1; bin0 = 8'd77; end
            if (k == 4) ena0 = 1'b0;
        end
        ena0 = 1'b0;
        check("ignore latency", 64'(k), 64'd9);
        check("ignore bcd", 64'(bcd0), 64'h200);
        repeat (2) @(negedge clk);
        check("ignore no second rdy", 64'(rdy0), 64'd0);

        // Reset mid-conversion aborts
        @(negedge clk);
        ena0 = 1'b1; bin0 = 8'd99;
        @(negedge clk);
        ena0 = 1'b0;
        for (int s = 2; s <= 4; s++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort rdy/busy/ovf", {61'd0, rdy0, busy0, ovf0}, 64'd0);
        check("abort bcd", 64'(bcd0), 64'd0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rdy0) seen = 1'b1;
        end
        check("abort no rdy", 64'(seen), 64'd0);

        // Random values against the decimal model
        for (int sel = 0; sel < 3; sel++) begin
            for (int n = 0; n < 15; n++) begin
                int v;
                v = (sel == 1) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 255));
                run_and_check($sformatf("rnd s%0d v%0d", sel, v), sel, 32'(v),
                              model_bcd(v, digits_of(sel)), model_ovf(v, digits_of(sel)),
                              model_blank(v, digits_of(sel)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
